alu_result_buffer: RTL

Downstream stage of the 16-bit ALU. Captures each ALU result Z and its flags (S, ZR, P, CY, OF) into a show-ahead FIFO with valid/ready handshakes on both sides. Keeps a last-flags register and a sticky overflow flag for the sequencer. Decouples the combinational ALU from a slower writeback consumer.

---
 rtl/alu_pkg.sv | 29 ++
 rtl/sync_fifo_mem.sv | 26 ++
 rtl/alu_result_buffer.sv | 153 +++++++++++++++
 3 files changed

// File: rtl/alu_pkg.sv
// Shared ALU definitions: data width, flag bit positions and the
// sign/zero/parity recompute used by the result buffer and the ALU bench.
package alu_pkg;

  localparam int ALU_W  = 16;

  localparam int FLG_S  = 0;
  localparam int FLG_ZR = 1;
  localparam int FLG_P  = 2;
  localparam int FLG_CY = 3;
  localparam int FLG_OF = 4;
  localparam int FLG_W  = 5;

  // Flags that can be derived purely from Z (carry and overflow cannot)
  localparam logic [FLG_W-1:0] SZP_MASK =
    FLG_W'((1 << FLG_S) | (1 << FLG_ZR) | (1 << FLG_P));

  // Recompute S, ZR and P from a result; CY and OF positions read 0.
  // P is 1 for an even number of ones.
  function automatic logic [FLG_W-1:0] calc_szp_flags(input logic [ALU_W-1:0] z);
    logic [FLG_W-1:0] f;
    f         = '0;
    f[FLG_S]  = z[ALU_W-1];
    f[FLG_ZR] = (z == '0);
    f[FLG_P]  = ~^z;
    return f;
  endfunction

endpackage

// File: rtl/sync_fifo_mem.sv
// Register-array storage for the result FIFO: one synchronous write port,
// one asynchronous read port. Contents are not reset.
module sync_fifo_mem #(
  parameter int DEPTH = 4,
  parameter int DW    = 21
) (
  input  logic                     clk,
  input  logic                     we,
  input  logic [$clog2(DEPTH)-1:0] waddr,
  input  logic [DW-1:0]            wdata,
  input  logic [$clog2(DEPTH)-1:0] raddr,
  output logic [DW-1:0]            rdata
);

  logic [DW-1:0] mem_q [DEPTH];

  // Write the addressed entry on an accepted push
  always_ff @(posedge clk) begin
    if (we) begin
      mem_q[waddr] <= wdata;
    end
  end

  assign rdata = mem_q[raddr];

endmodule

// File: rtl/alu_result_buffer.sv
// Show-ahead result FIFO between the ALU and the writeback consumer.
// Also tracks the flags of the latest push and a sticky overflow flag.
// Optional build macro FLAG_CHECK_EN adds a sticky S/ZR/P consistency check
// (flag_err); without it flag_err is tied low and no check logic exists.
module alu_result_buffer
  import alu_pkg::*;
#(
  parameter int WIDTH = ALU_W,
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [WIDTH-1:0]         z_in,
  input  logic                     s_in,
  input  logic                     zr_in,
  input  logic                     p_in,
  input  logic                     cy_in,
  input  logic                     of_in,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [WIDTH-1:0]         out_z,
  output logic [FLG_W-1:0]         out_flags,
  output logic [FLG_W-1:0]         last_flags,
  output logic                     of_sticky,
  input  logic                     clr,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     full,
  output logic                     empty,
  output logic                     flag_err
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam int DW = WIDTH + FLG_W;

  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]    count_q, count_d;
  logic [FLG_W-1:0] last_flags_q, last_flags_d;
  logic             of_sticky_q, of_sticky_d;
  logic [FLG_W-1:0] in_flags;
  logic [DW-1:0]    rd_data;
  logic             push, pop;

  // Pack the individual flag inputs into their package-defined positions
  always_comb begin
    in_flags         = '0;
    in_flags[FLG_S]  = s_in;
    in_flags[FLG_ZR] = zr_in;
    in_flags[FLG_P]  = p_in;
    in_flags[FLG_CY] = cy_in;
    in_flags[FLG_OF] = of_in;
  end

  assign full      = (count_q == CW'(DEPTH));
  assign empty     = (count_q == '0);
  assign in_ready  = ~full;
  assign out_valid = ~empty;
  assign push      = in_valid & in_ready;
  assign pop       = out_valid & out_ready;

  sync_fifo_mem #(
    .DEPTH (DEPTH),
    .DW    (DW)
  ) u_mem (
    .clk   (clk),
    .we    (push),
    .waddr (wr_ptr_q),
    .wdata ({in_flags, z_in}),
    .raddr (rd_ptr_q),
    .rdata (rd_data)
  );

  // Head entry is shown directly; an empty FIFO presents zeros, not stale data
  assign out_z      = empty ? '0 : rd_data[WIDTH-1:0];
  assign out_flags  = empty ? '0 : rd_data[DW-1:WIDTH];
  assign last_flags = last_flags_q;
  assign of_sticky  = of_sticky_q;
  assign count      = count_q;

  // Next-state for pointers, occupancy, last flags and sticky overflow
  always_comb begin
    wr_ptr_d     = wr_ptr_q;
    rd_ptr_d     = rd_ptr_q;
    count_d      = count_q;
    last_flags_d = last_flags_q;
    of_sticky_d  = clr ? 1'b0 : of_sticky_q;
    if (push) begin
      wr_ptr_d     = wr_ptr_q + AW'(1);
      last_flags_d = in_flags;
      if (of_in) begin
        of_sticky_d = 1'b1;
      end
    end
    if (pop) begin
      rd_ptr_d = rd_ptr_q + AW'(1);
    end
    case ({push, pop})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase
  end

  // State registers; reset discards every entry at once
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      count_q      <= '0;
      last_flags_q <= '0;
      of_sticky_q  <= 1'b0;
    end else begin
      wr_ptr_q     <= wr_ptr_d;
      rd_ptr_q     <= rd_ptr_d;
      count_q      <= count_d;
      last_flags_q <= last_flags_d;
      of_sticky_q  <= of_sticky_d;
    end
  end

`ifdef FLAG_CHECK_EN
  logic [FLG_W-1:0] calc_flags;
  logic             flag_mismatch;
  logic             flag_err_q, flag_err_d;

  // Compare received S/ZR/P against values recomputed from Z
  always_comb begin
    calc_flags    = calc_szp_flags(z_in);
    flag_mismatch = |((calc_flags ^ in_flags) & SZP_MASK);
    flag_err_d    = clr ? 1'b0 : flag_err_q;
    if (push && flag_mismatch) begin
      flag_err_d = 1'b1;
    end
  end

  // Sticky error register; a setting push wins over clr
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      flag_err_q <= 1'b0;
    end else begin
      flag_err_q <= flag_err_d;
    end
  end

  assign flag_err = flag_err_q;
`else
  assign flag_err = 1'b0;
`endif

endmodule
